// File: rtl/dircc_pmem_pkg.sv
// Shared types and constants for the processing-memory secondary (s2) port.
// Optional macro DIRCC_PMEM_ARB_LOCK_EN (used by the arbiter) adds per-requester lock inputs.
package dircc_pmem_pkg;

    localparam int PMEM_S2_ADDR_W = 14;
    localparam int PMEM_S2_DATA_W = 16;
    localparam int PMEM_S2_BE_W   = PMEM_S2_DATA_W / 8;

    typedef struct packed {
        logic [PMEM_S2_ADDR_W-1:0] address;
        logic [PMEM_S2_BE_W-1:0]   byteenable;
        logic [PMEM_S2_DATA_W-1:0] writedata;
        logic                      read;
        logic                      write;
    } pmem_req_t;

    typedef struct packed {
        logic valid;
        logic owner;
    } rd_tag_t;

endpackage

// File: rtl/dircc_rr_arb2.sv
// Two-way round-robin grant with a last_grant register; DIRCC_PMEM_ARB_LOCK_EN adds
// a lock that pins the grant to one requester until it issues an unlocked transfer.
module dircc_rr_arb2 (
`ifdef DIRCC_PMEM_ARB_LOCK_EN
    input  logic lock0,
    input  logic lock1,
`endif
    input  logic clk,
    input  logic reset_n,
    input  logic stall,
    input  logic req0,
    input  logic req1,
    output logic grant0,
    output logic grant1,
    output logic winner,
    output logic accept
);

    logic last_grant;
    logic pick;
    logic any_req;
`ifdef DIRCC_PMEM_ARB_LOCK_EN
    logic locked;
    logic lock_owner;
`endif

    always_comb begin
        pick    = 1'b0;
        any_req = req0 | req1;
        if (req0 && req1) begin
            pick = ~last_grant;
        end else if (req1) begin
            pick = 1'b1;
        end
`ifdef DIRCC_PMEM_ARB_LOCK_EN
        // While locked the other requester is invisible, even if it holds priority.
        if (locked) begin
            pick    = lock_owner;
            any_req = lock_owner ? req1 : req0;
        end
`endif
    end

    assign winner = any_req & pick;
    assign grant0 = any_req & ~pick;
    assign grant1 = any_req & pick;
    assign accept = any_req & ~stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= winner;
        end
    end

`ifdef DIRCC_PMEM_ARB_LOCK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            locked     <= 1'b0;
            lock_owner <= 1'b0;
        end else if (accept) begin
            locked     <= winner ? lock1 : lock0;
            lock_owner <= winner;
        end
    end
`endif

endmodule

// File: rtl/dircc_pmem_port2_arbiter.sv
// Shares the 16-bit s2 port of the processing memory between the NoC DMA (m0) and the
// debug/loader bridge (m1). Optional macro DIRCC_PMEM_ARB_LOCK_EN adds m0_lock/m1_lock.
module dircc_pmem_port2_arbiter
    import dircc_pmem_pkg::*;
#(
    parameter int ADDR_W = PMEM_S2_ADDR_W,
    parameter int DATA_W = PMEM_S2_DATA_W,
    parameter int BE_W   = DATA_W / 8,
    parameter int RD_LAT = 1
) (
`ifdef DIRCC_PMEM_ARB_LOCK_EN
    input  logic              m0_lock,
    input  logic              m1_lock,
`endif
    input  logic              clk,
    input  logic              reset_n,
    input  logic              reset_req,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address2,
    output logic [BE_W-1:0]   mem_byteenable2,
    output logic [DATA_W-1:0] mem_writedata2,
    output logic              mem_chipselect2,
    output logic              mem_write2,
    output logic              mem_clken2,
    input  logic [DATA_W-1:0] mem_readdata2
);

    // Handshake: a command completes in the cycle where read/write is high and waitrequest
    // is low; while waitrequest is high the master holds the command stable.
    pmem_req_t req_m0, req_m1, req_win;
    logic      grant0, grant1, winner, accept;
    rd_tag_t   rd_pipe [RD_LAT];
    rd_tag_t   rd_out;
    logic [DATA_W-1:0] rd_hold0, rd_hold1;

    assign req_m0 = '{address: m0_address, byteenable: m0_byteenable,
                      writedata: m0_writedata, read: m0_read, write: m0_write};
    assign req_m1 = '{address: m1_address, byteenable: m1_byteenable,
                      writedata: m1_writedata, read: m1_read, write: m1_write};

    dircc_rr_arb2 u_arb (
`ifdef DIRCC_PMEM_ARB_LOCK_EN
        .lock0   (m0_lock),
        .lock1   (m1_lock),
`endif
        .clk     (clk),
        .reset_n (reset_n),
        .stall   (reset_req),
        .req0    (m0_read | m0_write),
        .req1    (m1_read | m1_write),
        .grant0  (grant0),
        .grant1  (grant1),
        .winner  (winner),
        .accept  (accept)
    );

    assign req_win = winner ? req_m1 : req_m0;

    assign m0_waitrequest  = (m0_read | m0_write) & ~(grant0 & ~reset_req);
    assign m1_waitrequest  = (m1_read | m1_write) & ~(grant1 & ~reset_req);

    assign mem_address2    = req_win.address;
    assign mem_byteenable2 = req_win.byteenable;
    assign mem_writedata2  = req_win.writedata;
    assign mem_chipselect2 = accept;
    assign mem_write2      = accept & req_win.write;
    assign mem_clken2      = 1'b1;

    // The tag pipe advances in lock-step with the RAM's clock enable so tags stay aligned with data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                rd_pipe[i] <= '0;
            end
        end else if (!reset_req) begin
            rd_pipe[0] <= '{valid: accept & req_win.read & ~req_win.write, owner: winner};
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    assign rd_out           = rd_pipe[RD_LAT-1];
    assign m0_readdatavalid = rd_out.valid & ~rd_out.owner & ~reset_req;
    assign m1_readdatavalid = rd_out.valid &  rd_out.owner & ~reset_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_hold0 <= '0;
            rd_hold1 <= '0;
        end else begin
            if (m0_readdatavalid) rd_hold0 <= mem_readdata2;
            if (m1_readdatavalid) rd_hold1 <= mem_readdata2;
        end
    end

    assign m0_readdata = m0_readdatavalid ? mem_readdata2 : rd_hold0;
    assign m1_readdata = m1_readdatavalid ? mem_readdata2 : rd_hold1;

    a_m0_no_rw: assert property (@(posedge clk) disable iff (!reset_n) !(m0_read && m0_write));
    a_m1_no_rw: assert property (@(posedge clk) disable iff (!reset_n) !(m1_read && m1_write));

endmodule

// File: tb/tb_dircc_pmem_port2_arbiter.sv
// Directed bench for dircc_pmem_port2_arbiter with a behavioural s2 RAM (RD_LAT = 1).
// Define DIRCC_PMEM_ARB_LOCK_EN to also exercise the lock sequence.
module tb_dircc_pmem_port2_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        reset_req;
    logic        ram_init;
    logic [13:0] m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [1:0]  m0_byteenable, m1_byteenable;
    logic [15:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [15:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [13:0] mem_address2;
    logic [1:0]  mem_byteenable2;
    logic [15:0] mem_writedata2;
    logic        mem_chipselect2, mem_write2, mem_clken2;
    logic [15:0] mem_readdata2;
`ifdef DIRCC_PMEM_ARB_LOCK_EN
    logic        m0_lock, m1_lock;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] ram [0:16383];

    always #5 clk = ~clk;

    dircc_pmem_port2_arbiter dut (
`ifdef DIRCC_PMEM_ARB_LOCK_EN
        .m0_lock          (m0_lock),
        .m1_lock          (m1_lock),
`endif
        .clk              (clk),
        .reset_n          (reset_n),
        .reset_req        (reset_req),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_byteenable    (m0_byteenable),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_byteenable    (m1_byteenable),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address2     (mem_address2),
        .mem_byteenable2  (mem_byteenable2),
        .mem_writedata2   (mem_writedata2),
        .mem_chipselect2  (mem_chipselect2),
        .mem_write2       (mem_write2),
        .mem_clken2       (mem_clken2),
        .mem_readdata2    (mem_readdata2)
    );

    // s2 RAM: clock enable is the inverse of the global stall; preload pattern is addr ^ 0xA5A5.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 16384; i++) begin
                ram[i] <= 16'hA5A5 ^ 16'(i);
            end
        end else if (!reset_req && mem_chipselect2) begin
            if (mem_write2) begin
                if (mem_byteenable2[0]) ram[mem_address2][7:0]  <= mem_writedata2[7:0];
                if (mem_byteenable2[1]) ram[mem_address2][15:8] <= mem_writedata2[15:8];
            end else begin
                mem_readdata2 <= ram[mem_address2];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic m0_cmd(input logic rd, input logic wr, input logic [13:0] addr,
                          input logic [1:0] be, input logic [15:0] wd);
        m0_read = rd; m0_write = wr; m0_address = addr; m0_byteenable = be; m0_writedata = wd;
    endtask

    task automatic m1_cmd(input logic rd, input logic wr, input logic [13:0] addr,
                          input logic [1:0] be, input logic [15:0] wd);
        m1_read = rd; m1_write = wr; m1_address = addr; m1_byteenable = be; m1_writedata = wd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin : stim
        logic [13:0] m0_list [3];
        logic [13:0] m1_list [3];
        logic [13:0] acc_addr [6];
        logic [15:0] exp_data [6];
        m0_list  = '{14'h030, 14'h021, 14'h022};
        m1_list  = '{14'h041, 14'h042, 14'h043};
        acc_addr = '{14'h030, 14'h041, 14'h021, 14'h042, 14'h022, 14'h043};
        exp_data = '{16'hFFAB, 16'hA5E4, 16'hA584, 16'hA5E7, 16'hA587, 16'hA5E6};

        reset_n = 1'b0; reset_req = 1'b0; ram_init = 1'b1;
        m0_cmd(0, 0, '0, '0, '0);
        m1_cmd(0, 0, '0, '0, '0);
`ifdef DIRCC_PMEM_ARB_LOCK_EN
        m0_lock = 1'b0; m1_lock = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        check("rst_rdv0", 32'(m0_readdatavalid), 32'd0);
        check("rst_rdv1", 32'(m1_readdatavalid), 32'd0);
        check("rst_rd0", 32'(m0_readdata), 32'd0);
        check("rst_rd1", 32'(m1_readdata), 32'd0);
        check("rst_cs", 32'(mem_chipselect2), 32'd0);
        check("rst_clken", 32'(mem_clken2), 32'd1);
        @(negedge clk);
        reset_n = 1'b1; ram_init = 1'b0;

        // Single m0 write, m1 idle
        @(negedge clk);
        m0_cmd(0, 1, 14'h010, 2'b11, 16'hBEEF);
        #1;
        check("wr_wait0", 32'(m0_waitrequest), 32'd0);
        check("wr_wait1", 32'(m1_waitrequest), 32'd0);
        check("wr_cs", 32'(mem_chipselect2), 32'd1);
        check("wr_we", 32'(mem_write2), 32'd1);
        check("wr_addr", 32'(mem_address2), 32'h10);
        check("wr_data", 32'(mem_writedata2), 32'hBEEF);

        // Fill 0x30 with 0xFFFF, then m1 byte-lane-0 write of 0x12AB over it
        @(negedge clk);
        m0_cmd(0, 1, 14'h030, 2'b11, 16'hFFFF);
        #1;
        check("fill_we", 32'(mem_write2), 32'd1);
        @(negedge clk);
        m0_cmd(0, 0, '0, '0, '0);
        m1_cmd(0, 1, 14'h030, 2'b01, 16'h12AB);
        #1;
        check("bw_wait1", 32'(m1_waitrequest), 32'd0);
        check("bw_be", 32'(mem_byteenable2), 32'h1);
        check("bw_data", 32'(mem_writedata2), 32'h12AB);

        // Both read continuously: grants alternate starting with m0
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if ((c + 1) / 2 < 3) m0_cmd(1, 0, m0_list[(c + 1) / 2], 2'b11, '0);
            else                 m0_cmd(0, 0, '0, '0, '0);
            if (c / 2 < 3)       m1_cmd(1, 0, m1_list[c / 2], 2'b11, '0);
            else                 m1_cmd(0, 0, '0, '0, '0);
            #1;
            if (c <= 5) begin
                check($sformatf("rr_cs%0d", c), 32'(mem_chipselect2), 32'd1);
                check($sformatf("rr_addr%0d", c), 32'(mem_address2), 32'(acc_addr[c]));
                check($sformatf("rr_wait0_%0d", c), 32'(m0_waitrequest), 32'(c % 2 == 1 && c <= 4));
                check($sformatf("rr_wait1_%0d", c), 32'(m1_waitrequest), 32'(c % 2 == 0));
            end
            if (c >= 1) begin
                check($sformatf("rr_rdv0_%0d", c), 32'(m0_readdatavalid), 32'((c - 1) % 2 == 0));
                check($sformatf("rr_rdv1_%0d", c), 32'(m1_readdatavalid), 32'((c - 1) % 2 == 1));
                if ((c - 1) % 2 == 0)
                    check($sformatf("rr_rd0_%0d", c), 32'(m0_readdata), 32'(exp_data[c - 1]));
                else
                    check($sformatf("rr_rd1_%0d", c), 32'(m1_readdata), 32'(exp_data[c - 1]));
            end
            if (c == 2) check("rr_hold0", 32'(m0_readdata), 32'hFFAB);
        end

        // m1 reads addr 5, then reset_req held for 3 cycles with both requesting
        @(negedge clk);
        m0_cmd(0, 0, '0, '0, '0);
        m1_cmd(1, 0, 14'h005, 2'b11, '0);
        #1;
        check("st_acc", 32'(m1_waitrequest), 32'd0);
        for (int s = 1; s <= 3; s++) begin
            @(negedge clk);
            reset_req = 1'b1;
            m0_cmd(1, 0, 14'h006, 2'b11, '0);
            m1_cmd(1, 0, 14'h007, 2'b11, '0);
            #1;
            check($sformatf("st_wait0_%0d", s), 32'(m0_waitrequest), 32'd1);
            check($sformatf("st_wait1_%0d", s), 32'(m1_waitrequest), 32'd1);
            check($sformatf("st_rdv1_%0d", s), 32'(m1_readdatavalid), 32'd0);
            check($sformatf("st_cs_%0d", s), 32'(mem_chipselect2), 32'd0);
        end
        @(negedge clk);
        reset_req = 1'b0;
        #1;
        check("st_rdv1", 32'(m1_readdatavalid), 32'd1);
        check("st_rd1", 32'(m1_readdata), 32'hA5A0);
        check("st_wait0", 32'(m0_waitrequest), 32'd0);
        check("st_wait1", 32'(m1_waitrequest), 32'd1);
        @(negedge clk);
        m0_cmd(0, 0, '0, '0, '0);
        #1;
        check("st_rdv0", 32'(m0_readdatavalid), 32'd1);
        check("st_rd0", 32'(m0_readdata), 32'hA5A3);
        check("st_wait1b", 32'(m1_waitrequest), 32'd0);
        @(negedge clk);
        m1_cmd(0, 0, '0, '0, '0);
        #1;
        check("st_rdv1b", 32'(m1_readdatavalid), 32'd1);
        check("st_rd1b", 32'(m1_readdata), 32'hA5A2);

        // Reset while an m0 read is in flight
        @(negedge clk);
        m0_cmd(1, 0, 14'h008, 2'b11, '0);
        #1;
        check("rf_acc", 32'(m0_waitrequest), 32'd0);
        @(negedge clk);
        m0_cmd(0, 0, '0, '0, '0);
        reset_n = 1'b0;
        #1;
        check("rf_rdv0", 32'(m0_readdatavalid), 32'd0);
        check("rf_rd0", 32'(m0_readdata), 32'd0);
        check("rf_rd1", 32'(m1_readdata), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        m0_cmd(1, 0, 14'h009, 2'b11, '0);
        m1_cmd(1, 0, 14'h00A, 2'b11, '0);
        #1;
        check("rf_wait0", 32'(m0_waitrequest), 32'd0);
        check("rf_wait1", 32'(m1_waitrequest), 32'd1);
        check("rf_rdv0b", 32'(m0_readdatavalid), 32'd0);
        @(negedge clk);
        m0_cmd(0, 0, '0, '0, '0);
        #1;
        check("rf_rdv0c", 32'(m0_readdatavalid), 32'd1);
        check("rf_rd0c", 32'(m0_readdata), 32'hA5AC);
        check("rf_wait1b", 32'(m1_waitrequest), 32'd0);
        @(negedge clk);
        m1_cmd(0, 0, '0, '0, '0);
        #1;
        check("rf_rdv1", 32'(m1_readdatavalid), 32'd1);
        check("rf_rd1b", 32'(m1_readdata), 32'hA5AF);
        check("rf_rdv0d", 32'(m0_readdatavalid), 32'd0);

`ifdef DIRCC_PMEM_ARB_LOCK_EN
        // m0 locked read, idle gap, unlocking write; m1 requests throughout
        @(negedge clk);
        m0_cmd(1, 0, 14'h010, 2'b11, '0); m0_lock = 1'b1;
        m1_cmd(1, 0, 14'h011, 2'b11, '0);
        #1;
        check("lk_wait0", 32'(m0_waitrequest), 32'd0);
        check("lk_wait1", 32'(m1_waitrequest), 32'd1);
        @(negedge clk);
        m0_cmd(0, 0, '0, '0, '0); m0_lock = 1'b0;
        #1;
        check("lk_hold1", 32'(m1_waitrequest), 32'd1);
        check("lk_cs", 32'(mem_chipselect2), 32'd0);
        check("lk_rd0", 32'(m0_readdata), 32'hBEEF);
        @(negedge clk);
        m0_cmd(0, 1, 14'h010, 2'b11, 16'h1234);
        #1;
        check("lk_unl0", 32'(m0_waitrequest), 32'd0);
        check("lk_unl1", 32'(m1_waitrequest), 32'd1);
        @(negedge clk);
        m0_cmd(0, 0, '0, '0, '0);
        #1;
        check("lk_grant1", 32'(m1_waitrequest), 32'd0);
        check("lk_addr", 32'(mem_address2), 32'h11);
        @(negedge clk);
        m1_cmd(0, 0, '0, '0, '0);
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dircc_pmem_port2_arbiter.md
Name: dircc_pmem_port2_arbiter

Overview:
- Shares the 16-bit secondary port (s2) of a node's dual-port processing memory between two Avalon-MM requesters.
- Requester 0 is the NoC receive/transmit DMA; requester 1 is the debug/loader bridge. The 32-bit port stays owned by the Nios core.
- Round-robin arbitration, zero-cycle accept, fixed-latency read return routed back to the issuing requester.
- Honours the memory's global stall (reset_req), which freezes the RAM clock enable.

Parameters:
- ADDR_W, 14, word address width of s2 (10000 x 16-bit words).
- DATA_W, 16, s2 data width.
- BE_W, 2, byteenable width (DATA_W/8).
- RD_LAT, 1, s2 read latency in cycles (legal values: 1 or 2).

Ports:
- clk  in  1  single clock for arbiter and memory.
- reset_n  in  1  asynchronous, active-low reset.
- reset_req  in  1  memory stall request; while high, no transfer is accepted.
- mN_address  in  ADDR_W  requester N word address (N = 0, 1).
- mN_read / mN_write  in  1  requester N command.
- mN_byteenable  in  BE_W  requester N byte lanes.
- mN_writedata  in  DATA_W  requester N write data.
- mN_waitrequest  out  1  requester N stall.
- mN_readdata  out  DATA_W  requester N read data.
- mN_readdatavalid  out  1  requester N read data strobe.
- mem_address2  out  ADDR_W  to memory address2.
- mem_byteenable2  out  BE_W  to memory byteenable2.
- mem_writedata2  out  DATA_W  to memory writedata2.
- mem_chipselect2 / mem_write2 / mem_clken2  out  1  to memory.
- mem_readdata2  in  DATA_W  from memory readdata2.

Behaviour:
- Request: reqN = mN_read | mN_write. Having read and write high together on the same requester is illegal; write takes precedence, and an assertion flags it in simulation.
- Grant (combinational): only one requester asserts req, so it wins. Both assert req, so the winner is the requester not equal to last_grant. Neither asserts req, so there is no grant.
- Accept: granted & ~reset_req. mN_waitrequest = reqN & ~(grantN & ~reset_req).
- A non-requesting master sees waitrequest = 0.
- Memory drive:
  - mem_chipselect2 = accept.
  - mem_write2 = accept & write of the winner.
  - mem_address2, byteenable2 and writedata2 are muxed from the winner, or from m0 when idle.
  - mem_clken2 = 1 always (the stall is carried by reset_req on the memory's own clocken0).
- last_grant register: updated to the winner on each accepted transfer; held otherwise. Reset value 1, so requester 0 wins the first contention.
- Read return pipeline:
  - An RD_LAT-deep shift register of {valid, owner}, advanced only while ~reset_req (it matches the RAM's frozen clock enable).
  - Stage 0 is loaded with {accept & read, winner}.
  - At the output stage, mOwner_readdatavalid = 1 and mOwner_readdata = mem_readdata2.
  - The non-owner sees readdatavalid = 0; its readdata is held at the last value.
- Throughput: one transfer per cycle. Back-to-back reads from alternating requesters return in issue order, RD_LAT cycles after each accept.
- reset_req mid-transfer: all waitrequests assert, the pipeline freezes, and no readdatavalid is emitted while it is high. Flow resumes exactly where it stopped once it drops.
- Reset (async assert, sync deassert handled upstream): last_grant = 1, pipeline valids = 0, all readdatavalid = 0, readdata registers = 0. In-flight reads are discarded.
- Outputs that are combinational with reqs while idle are 0.

Optional Feature:
- Macro DIRCC_PMEM_ARB_LOCK_EN adds inputs m0_lock and m1_lock (1 bit).
- With the macro defined:
  - An accepted transfer with mN_lock = 1 sets locked = 1, lock_owner = N.
  - While locked, only lock_owner can be granted; the other requester waits even if it has priority.
  - The lock is released on the first accepted transfer of lock_owner with lock = 0, or by reset.
  - Intended for DMA descriptor read-modify-write.
- Without the macro: no lock ports, pure round-robin.

Decomposition:
- Package dircc_pmem_pkg:
  - Constants PMEM_S2_ADDR_W = 14 and PMEM_S2_DATA_W = 16.
  - typedef pmem_req_t {address, byteenable, writedata, read, write}.
  - typedef rd_tag_t {valid, owner}.
- One sub-module, dircc_rr_arb2: a 2-way round-robin grant with a last_grant register (and lock logic when enabled).
- The top level holds the muxes and the read pipeline.

Test Plan:
- m0 writes 0xBEEF to addr 0x0010 while m1 is idle. Expect m0 accepted the same cycle with mem_write2 = 1 and mem_address2 = 0x0010; m1_waitrequest = 0.
- m0 and m1 read continuously in the same cycles. Expect grants to alternate 0,1,0,1 and exactly one accept per cycle. Each readdatavalid goes only to the issuer, RD_LAT cycles later, with data matching a memory model.
- m1 reads addr 5, then reset_req is held high for 3 cycles in the next cycle. Expect both waitrequests high, no readdatavalid for 3 cycles; m1 data delivered after release with the correct value.
- reset_n pulsed low while a read is in flight. Expect no readdatavalid after reset, and m0 to win the first post-reset contention.
- Byte write with m1_byteenable = 2'b01 and data 0x12AB over a location holding 0xFFFF. Expect readback 0xFFAB.
- With DIRCC_PMEM_ARB_LOCK_EN: m0 issues locked read, write with lock = 0 while m1 requests throughout. Expect m1 to wait until m0's unlocking write is accepted, then m1 is granted the next cycle.
